// File: rtl/cpu_pkg.sv
// Shared CPU constants for the fetch front end: instruction width, PC step
// and default address MSB index.
package cpu_pkg;

  localparam int INSTR_W    = 16;
  localparam int PC_STEP    = 2;
  localparam int NS_DEFAULT = 7;

endpackage : cpu_pkg

// File: rtl/instr_fetch_if.sv
// Instruction-memory port plus decode handshake and redirect request.
// The master side is the fetch unit; the slave side is memory/decode.
interface instr_fetch_if
  import cpu_pkg::*;
#(
  parameter int NS = NS_DEFAULT
);

  logic [NS:0]        addr;
  logic [INSTR_W-1:0] instr;
  logic [INSTR_W-1:0] ir;
  logic [NS:0]        ir_pc;
  logic               ir_valid;
  logic               ir_ready;
  logic               br_valid;
  logic [NS:0]        br_target;

  modport master (
    output addr, ir, ir_pc, ir_valid,
    input  instr, ir_ready, br_valid, br_target
  );

  modport slave (
    input  addr, ir, ir_pc, ir_valid,
    output instr, ir_ready, br_valid, br_target
  );

endinterface : instr_fetch_if

// File: rtl/fetch_buf.sv
// Two-entry in-order FIFO holding {instruction, pc} pairs between the
// instruction memory and decode; flush empties it in one edge.
module fetch_buf #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output logic [W-1:0] head_data,
  output logic         head_valid
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;

  assign count      = count_q;
  assign head_valid = (count_q != 2'd0);
  assign head_data  = mem_q[rd_ptr_q];

  // NOTE: combinational blocks use blocking '=' and give every output a
  // default first, so no path through the block can infer a latch.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: sequential blocks use non-blocking '<=' so every flop samples its
  // pre-edge value. The storage is reset too, because the head word must
  // read as zero straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && !pop && count_q == 2'd2));

  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !(pop && !flush && count_q == 2'd0));

endmodule : fetch_buf

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, issues one read per cycle while the
// buffer has room, captures the one-cycle-late response and handles redirects.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int          NS     = NS_DEFAULT,
  parameter logic [NS:0] RST_PC = '0
) (
  input  logic           clk,
  input  logic           rst,
  instr_fetch_if.master  bus
);

  localparam int          ENTRY_W    = INSTR_W + NS + 1;
  localparam logic [NS:0] ALIGN_MASK = ~(NS + 1)'(1);
  localparam logic [NS:0] RST_ADDR   = RST_PC & ALIGN_MASK;
  localparam logic [NS:0] STEP       = (NS + 1)'(PC_STEP);

  logic [NS:0]        pc_q, pc_d;
  logic               inflight_q, inflight_d;
  logic [NS:0]        inflight_pc_q, inflight_pc_d;

  logic               pop, push, flush, issue;
  logic [2:0]         occ_next;
  logic [1:0]         buf_count;
  logic [ENTRY_W-1:0] head_data;
  logic               head_valid;

  assign bus.addr     = pc_q;
  assign bus.ir       = head_data[ENTRY_W-1 -: INSTR_W];
  assign bus.ir_pc    = head_data[NS:0];
  assign bus.ir_valid = head_valid;

  always_comb begin
    pop   = head_valid & bus.ir_ready;
    flush = bus.br_valid;
    push  = inflight_q & ~bus.br_valid;
    // Occupancy after this edge, counting the read that is still in flight.
    occ_next = 3'(buf_count) + 3'(inflight_q) - 3'(pop);
    issue    = ~bus.br_valid & (occ_next < 3'd2);

    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (bus.br_valid) begin
      pc_d = bus.br_target & ALIGN_MASK;
    end else if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RST_ADDR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_buf #(.W(ENTRY_W)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  ({bus.instr, inflight_pc_q}),
    .pop        (pop),
    .flush      (flush),
    .count      (buf_count),
    .head_data  (head_data),
    .head_valid (head_valid)
  );

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a vector table for streaming, redirect,
// wrap and back-to-back redirects, plus sequences for stall and reset cases.
module tb_instr_fetch;

  localparam int NS = 7;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        br;
    logic [7:0]  tgt;
    logic        v;
    logic [15:0] ir;
    logic [7:0]  pc;
    logic [7:0]  addr;
  } vec_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [15:0] mem [128];
  vec_t        vecs [21];

  instr_fetch_if #(.NS(NS)) bus ();

  instr_fetch #(.NS(NS), .RST_PC(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: returns the word for the address seen at the last edge.
  always @(posedge clk) bus.instr <= mem[bus.addr[NS:1]];

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, take the edge, then compare registered outputs.
  task automatic cyc(input logic r, input logic rdy, input logic br,
                     input logic [7:0] tgt, input logic v,
                     input logic [15:0] ir, input logic [7:0] pc,
                     input logic [7:0] addr);
    rst           = r;
    bus.ir_ready  = rdy;
    bus.br_valid  = br;
    bus.br_target = tgt;
    @(posedge clk);
    #1;
    check("ir_valid", 16'(bus.ir_valid), 16'(v));
    check("addr", 16'(bus.addr), 16'(addr));
    if (v || r) begin
      check("ir", bus.ir, ir);
      check("ir_pc", 16'(bus.ir_pc), 16'(pc));
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 128; i++) mem[i] = 16'hA000 | 16'(i);
    mem[0] = 16'hF120;
    mem[1] = 16'hF121;
    mem[2] = 16'h93FF;
    mem[3] = 16'h834C;
    mem[8] = 16'hF468;

    //             rst   rdy   br    tgt    v     ir        pc     addr
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h02};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'hF120, 8'h00, 8'h04};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'hF121, 8'h02, 8'h06};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h93FF, 8'h04, 8'h08};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h834C, 8'h06, 8'h0A};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 16'h0000, 8'h00, 8'h10};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h12};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'hF468, 8'h10, 8'h14};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'hA009, 8'h12, 8'h16};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 8'hFC, 1'b0, 16'h0000, 8'h00, 8'hFC};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'hFE};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'hA07E, 8'hFC, 8'h00};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'hA07F, 8'hFE, 8'h02};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'hF120, 8'h00, 8'h04};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'hF121, 8'h02, 8'h06};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 16'h0000, 8'h00, 8'h20};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 8'h31, 1'b0, 16'h0000, 8'h00, 8'h30};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h32};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'hA018, 8'h30, 8'h34};

    rst           = 1'b1;
    bus.ir_ready  = 1'b0;
    bus.br_valid  = 1'b0;
    bus.br_target = 8'h00;
    @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++) begin
      cyc(vecs[i].rst, vecs[i].rdy, vecs[i].br, vecs[i].tgt,
          vecs[i].v, vecs[i].ir, vecs[i].pc, vecs[i].addr);
    end

    // Stall from reset: buffer fills, addr freezes, then drains gap-free.
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h02);
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'hF120, 8'h00, 8'h04);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'hF121, 8'h02, 8'h06);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h93FF, 8'h04, 8'h08);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h834C, 8'h06, 8'h0A);

    // Redirect together with a pop while the buffer is full.
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h02);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'hF120, 8'h00, 8'h04);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'hF120, 8'h00, 8'h04);
    cyc(1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 16'h0000, 8'h00, 8'h10);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h12);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'hF468, 8'h10, 8'h14);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'hA009, 8'h12, 8'h16);

    // Reset pulse with a full buffer, then re-fetch from the reset PC.
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h02);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'hF120, 8'h00, 8'h04);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'hF120, 8'h00, 8'h04);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h02);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'hF120, 8'h00, 8'h04);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'hF121, 8'h02, 8'h06);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_instr_fetch

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the requesting end of the instruction-memory port. It owns the program counter and drives the byte address into the instruction memory. The memory returns the 16-bit instruction one clock later, and this unit buffers it in a 2-entry queue. The decode stage takes instructions through a valid/ready handshake, and taken branches or jumps redirect the fetch stream.

## Interface
- NS, 7, address MSB index; address bus is NS+1 bits (byte address).
- RST_PC, 0, PC value loaded by reset; bit 0 is ignored (treated as 0).
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- addr  out  NS+1  byte address to instruction memory; always equals the PC register.
- instr  in  16  memory read data; holds the word for the addr sampled at the previous posedge.
- ir  out  16  instruction at buffer head.
- ir_pc  out  NS+1  byte address of ir.
- ir_valid  out  1  buffer head holds a valid instruction.
- ir_ready  in  1  decode accepts ir this cycle.
- br_valid  in  1  redirect request.
- br_target  in  NS+1  redirect byte address; bit 0 is forced to 0.

## Operation
- Reset: pc=RST_PC & ~1; inflight=0; buffer count=0; ir_valid=0; ir=16'h0000; ir_pc=0; addr=RST_PC & ~1.
- pop = ir_valid & ir_ready.
- issue = !br_valid & (count + inflight - pop < 2).
- On issue:
  - inflight<=1, inflight_pc<=pc.
  - pc <= pc+2, modulo 2^(NS+1), so 0xFE wraps to 0x00.
- Without issue: inflight<=0 and pc holds. The memory still re-reads addr, but that response is ignored.
- Capture: if inflight & !br_valid, push {instr, inflight_pc} into the buffer at this edge.
- Buffer: 2-entry FIFO, in-order. Push and pop may occur in the same cycle; count is unchanged when both happen. The issue rule guarantees no push into a full buffer, and an overflow is a design error (assertion).
- Redirect (br_valid=1), highest priority:
  - A pop in the same cycle completes normally; decode has consumed that instruction.
  - Then flush: count<=0, inflight<=0, and the in-flight response is discarded.
  - pc<=br_target & ~1. No issue this cycle.
- Back-to-back br_valid: the last one wins, and nothing is issued while br_valid is held.
- ir/ir_pc hold their values while ir_valid=1 & ir_ready=0, and are don't-care when ir_valid=0.
- Flow states, implicit in the registers:
  - RUN: issuing.
  - FULL: count+inflight=2, no pop.
  - REDIRECT: the cycle with br_valid.
  - Transitions: RUN to FULL when decode stalls. FULL to RUN on the first pop. Any state to REDIRECT on br_valid. REDIRECT to RUN on the next cycle.

## Timing
- Edges are numbered from E0, the first posedge with rst=0.
  - E0: RST_PC issued.
  - E1: captured. ir_valid=1 after E1 with ir=mem[RST_PC/2].
  - Latency from issue to ir_valid is 2 edges.
- Throughput: 1 instruction per cycle while ir_ready=1 continuously.
- Redirect at edge R: target issued at R+1, ir_valid with the target instruction after R+2. ir_valid=0 after R and after R+1.
- Stall: with ir_ready=0 from reset, after E2 the buffer holds 2 entries and issue stops.
  - addr freezes at RST_PC+4.
  - On the first pop, issue resumes in the same cycle.
- rst asserted mid-stream: all state returns to reset values at that edge, and any in-flight response is discarded.
- Combinational paths: ir_ready and br_valid feed internal next-state only. addr and all other outputs are registered.

## Structure
- Shared package cpu_pkg:
  - INSTR_W=16.
  - PC step constant = 2.
  - NS default.
- Sub-module fetch_buf: 2-entry FIFO, width 16+NS+1, with push/pop/flush ports, count output and head outputs. Instantiated once.
- Top level holds pc, inflight, inflight_pc and the issue/redirect logic.

## Test plan
- Reset, then ir_ready=1 with mem[0..3]=F120,F121,93FF,834C:
  - ir_valid rises after E1.
  - ir sequence F120@0x00, F121@0x02, 93FF@0x04, 834C@0x06, one per cycle.
- ir_ready=0 for 5 cycles after reset:
  - ir holds F120@0x00.
  - addr frozen at 0x04.
  - ir_ready=1 then yields F120, F121, 93FF with no gap or duplicate.
- br_valid with br_target=0x11 while streaming:
  - Next two cycles ir_valid=0.
  - Then ir=mem[8]=F468 with ir_pc=0x10; no stale word from before the branch appears.
- br_valid in the same cycle as a pop:
  - The popped instruction counts as consumed.
  - The buffered and in-flight words are dropped.
  - The target word is delivered after 2 edges.
- Wrap: br_target=0xFC with ir_ready=1 → ir_pc sequence 0xFC, 0xFE, 0x00, 0x02.
- rst pulse mid-stream with a full buffer:
  - After the reset edge, ir_valid=0 and addr=RST_PC.
  - Re-fetch starts from mem[0].
